// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded instruction fields into MIPS32 words
// and writes them to consecutive instruction-memory addresses.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic {LOAD, FULL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_nxt;
    logic [5:0]        opcode;
    logic [31:0]       enc;
    logic              xfer, illegal, wr_fire;

    assign opcode   = {2'b00, op_sel};
    assign full     = (state_q == FULL);
    assign in_ready = rst_n && !full && !clear;
    assign xfer     = in_valid && in_ready;
    assign illegal  = (op_sel == 4'd15);
    assign wr_fire  = xfer && !illegal;
    assign cnt_nxt  = word_count + 1'b1;

    always_comb begin
        enc = (op_sel == 4'd0)  ? {opcode, rs, rt, rd, shamt, funct} :
              (op_sel <= 4'd11) ? {opcode, rs, rt, imm} :
              (op_sel <= 4'd13) ? {opcode, target} :
                                  {opcode, rs, 21'b0};
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = LOAD;
        else if (wr_fire && cnt_nxt == DEPTH_C)
            state_d = FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // Write port is registered: the word appears one cycle after its transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= BASE_C;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_C;
            wr_data    <= 32'd0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            wr_en <= wr_fire;
            err   <= xfer && illegal;
            if (clear) begin
                addr_q     <= BASE_C;
                word_count <= '0;
            end else if (wr_fire) begin
                wr_addr    <= addr_q;
                wr_data    <= enc;
                addr_q     <= addr_q + 1'b1;
                word_count <= cnt_nxt;
            end
        end
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the opcode decoder. Takes decoded instruction fields (instruction class plus register, immediate and target fields) over a valid/ready handshake.
- Packs each accepted instruction into a 32-bit MIPS32 word using the team's 4-bit-class opcode map.
- Writes the words to consecutive instruction-memory addresses through a registered write port.
- Used by the testbench and boot path to load programs into the single-cycle core's instruction memory.

Parameters:
ADDR_W, 8, width of instruction-memory word address.
DEPTH, 256, number of words loadable before full; legal range 1..2^ADDR_W.
BASE_ADDR, 0, first word address written after reset or clear.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  reset, asynchronous and active-low.
clear  in  1  synchronous restart: address to BASE_ADDR, count to 0, full cleared.
in_valid  in  1  field bundle valid.
in_ready  out  1  encoder can accept this cycle.
op_sel  in  4  class: 0 R-type, 1 sw, 2 lw, 3 addi, 4 andi, 5 ori, 6 beq, 7 bne, 8 bge, 9 bgt, 10 ble, 11 blt, 12 j, 13 jal, 14 jr, 15 illegal.
rs  in  5  source register.
rt  in  5  second source / I-type destination.
rd  in  5  R-type destination.
shamt  in  5  R-type shift amount.
funct  in  6  R-type function code.
imm  in  16  I-type immediate / branch offset, passed raw.
target  in  26  J-type target.
wr_en  out  1  instruction-memory write strobe.
wr_addr  out  ADDR_W  write word address.
wr_data  out  32  encoded instruction.
word_count  out  ADDR_W+1  words written since reset/clear.
full  out  1  DEPTH words written.
err  out  1  one-cycle pulse: illegal op_sel dropped.

Behaviour:
- Reset values: in_ready 0 while rst_n low, 1 after release. wr_en 0, wr_addr BASE_ADDR, wr_data 0, word_count 0, full 0, err 0.
- in_ready = !full && !clear. Transfer occurs when in_valid && in_ready.
- Encoding (opcode = op_sel zero-extended to 6 bits in [31:26]):
  - R-type: {opcode, rs, rt, rd, shamt, funct}.
  - Classes 1-11: {opcode, rs, rt, imm}.
  - 12, 13: {opcode, target}.
  - 14: {opcode, rs, 21'b0}.
  - Fields a class does not use are ignored. No sign manipulation of imm.
- Latency: one cycle. A transfer in cycle N gives wr_en=1 in cycle N+1, with wr_addr = current address and wr_data = encoded word. Throughput is one word per cycle with back-to-back transfers.
- After each write: address increments by 1 (wraps modulo 2^ADDR_W, only reachable if BASE_ADDR+DEPTH exceeds range) and word_count increments.
- full asserts in the same cycle as the write that makes word_count == DEPTH. That cycle is word_count = DEPTH, wr_en = 1, in_ready = 0. full holds until clear or reset.
- Illegal op_sel (15): transfer completes (handshake consumed), no write, address and count unchanged. err = 1 for one cycle at N+1.
- clear: takes priority over a simultaneous transfer (in_ready already 0). Any write pending from the previous cycle still issues at the old address. Afterwards address = BASE_ADDR, count 0, full 0.
- in_valid with in_ready low: no state change. The producer must hold its fields.
- rst_n low at any time: immediate return to reset values, pending write discarded.
- State machine: LOAD (accepting) -> FULL when word_count reaches DEPTH; FULL -> LOAD on clear.

Test Plan:
- Reset release, then addi rs=1 rt=2 imm=0x0005 -> next cycle wr_en=1, wr_addr=0, wr_data=0x0C220005, word_count=1.
- Back-to-back R-type rs=3 rt=4 rd=5 shamt=0 funct=0x20, then beq rs=1 rt=2 imm=0xFFFE -> consecutive writes 0x00642820 @0, 0x1822FFFE @1, no bubble.
- jal target=0x0000010, then jr rs=31 with rt/imm nonzero -> 0x34000010, then 0x3BE00000 (unused fields zeroed).
- op_sel=15 between two valid ops -> err pulse, no wr_en that cycle, next valid op written at the following address, count skips nothing.
- DEPTH=4: stream 5 ops -> 4 writes at addresses 0..3, full=1 and in_ready=0 after the 4th, 5th held. Assert clear -> 5th written at BASE_ADDR, word_count=1.
- rst_n dropped in the cycle after a transfer -> no wr_en, all outputs at reset values asynchronously.
